// File: rtl/btn_pkg.sv
// Shared BCD types and single-digit increment/decrement helpers for the button counters.
package btn_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef struct packed {
    logic       c;
    bcd_digit_t d;
  } bcd_step_t;

  // Add cin to one decimal digit; c reports a carry out of 9.
  function automatic bcd_step_t bcd_inc(input bcd_digit_t d, input logic cin);
    bcd_step_t r;
    r.c = cin && (d >= BCD_MAX);
    if (!cin)              r.d = d;
    else if (d >= BCD_MAX) r.d = 4'd0;
    else                   r.d = d + 4'd1;
    return r;
  endfunction

  // Subtract bin from one decimal digit; c reports a borrow out of 0.
  function automatic bcd_step_t bcd_dec(input bcd_digit_t d, input logic bin);
    bcd_step_t r;
    r.c = bin && (d == 4'd0);
    if (!bin)            r.d = d;
    else if (d == 4'd0)  r.d = BCD_MAX;
    else if (d > BCD_MAX) r.d = BCD_MAX;
    else                 r.d = d - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; rise_c marks the edge where the clean level goes 0->1.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic db,
  output logic rise_c
);

  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          done_c;

  // Level flips on the edge where the counter would reach DEB_CYCLES.
  assign done_c = (s2 != db) && (cnt == CW'(DEB_CYCLES - 1));
  assign rise_c = done_c && s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (done_c) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_bcd_counter.sv
// Debounced push-button BCD up/down counter with wrap/saturate, stop and clear.
// Optional hold-to-repeat events are built when HOLD_REPEAT_EN is defined.
module btn_bcd_counter
  import btn_pkg::*;
#(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned SATURATE   = 0,
  parameter int unsigned REP_DELAY  = 8,
  parameter int unsigned REP_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn,
  input  logic                  stop,
  input  logic                  dir,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  press_pulse,
  output logic                  wrap_pulse
);

  localparam int unsigned BW = 4 * DIGITS;

  if (DIGITS < 1 || DEB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_param
    $error("btn_bcd_counter: DIGITS, DEB_CYCLES, REP_DELAY and REP_PERIOD must be >= 1");
  end

  logic          db;
  logic          rise_c;
  logic          rep_ev_c;
  logic          ev_c;
  logic [BW-1:0] nxt_c;
  logic          lim_c;
  logic          carry_c;
  bcd_step_t     step_c;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .db     (db),
    .rise_c (rise_c)
  );

`ifdef HOLD_REPEAT_EN
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RW      = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;

  // First repeat waits REP_DELAY after the press, later ones REP_PERIOD apart.
  assign rep_ev_c = db && (rep_cnt == (rep_first ? RW'(REP_DELAY - 1) : RW'(REP_PERIOD - 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (!db) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_ev_c) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  // Held level only matters to the repeat logic, absent in this build.
  assign rep_ev_c = db & 1'b0;
`endif

  assign ev_c = rise_c | rep_ev_c;

  // Ripple +/-1 across digits; the final carry/borrow flags a count limit.
  always_comb begin
    nxt_c   = bcd;
    carry_c = 1'b1;
    step_c  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      step_c = dir ? bcd_dec(bcd[4*i +: 4], carry_c) : bcd_inc(bcd[4*i +: 4], carry_c);
      nxt_c[4*i +: 4] = step_c.d;
      carry_c = step_c.c;
    end
    lim_c = carry_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd         <= '0;
      press_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      press_pulse <= ev_c;
      wrap_pulse  <= 1'b0;
      if (clear) begin
        bcd <= '0;
      end else if (stop) begin
        bcd <= bcd;
      end else if (ev_c) begin
        wrap_pulse <= lim_c;
        if (!((SATURATE != 0) && lim_c)) bcd <= nxt_c;
      end
    end
  end

endmodule
